// File: rtl/output_unit.sv
// Link transmit stage: stages switch flits and writes them into the neighbour FIFO under full/almost_full backpressure.
// Optional statistics counters are enabled with `define OUTPUT_UNIT_STAT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module output_unit #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_valid,
    input  logic [`DATA_WIDTH-1:0] sw_data,
    output logic                   sw_ready,
    input  logic                   ds_almost_full,
    input  logic                   ds_full,
    output logic                   data_valid_out,
    output logic [`DATA_WIDTH-1:0] data_out,
    output logic                   stall,
    output logic [PTR_W:0]         buf_count
`ifdef OUTPUT_UNIT_STAT_EN
    ,
    input  logic                   stat_clr,
    output logic [15:0]            flit_cnt,
    output logic [15:0]            stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [`DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic                   data_valid_q, data_valid_d;
    logic [`DATA_WIDTH-1:0] data_q, data_d;
    logic                   stall_q, stall_d;
    state_t                 state_q, state_d;

    logic accept_s, send_ok_s, pending_s, send_s, buf_empty_s, rd_s, wr_s;

    // The one-flit margin: a write in flight plus almost_full forbids the next write.
    assign sw_ready    = (count_q < CNT_FULL);
    assign accept_s    = sw_valid && sw_ready;
    assign send_ok_s   = !ds_full && !(ds_almost_full && data_valid_q);
    assign buf_empty_s = (count_q == CNT_ZERO);
    assign pending_s   = !buf_empty_s || accept_s;
    assign send_s      = send_ok_s && pending_s;
    assign rd_s        = send_s && !buf_empty_s;
    assign wr_s        = accept_s && !(send_s && buf_empty_s);

    assign data_valid_out = data_valid_q;
    assign data_out       = data_q;
    assign stall          = stall_q;
    assign buf_count      = count_q;

    // Staging datapath next-state: pointers, occupancy and link register.
    always_comb begin
        rd_ptr_d     = rd_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d     = wr_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        count_d      = count_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        case ({wr_s, rd_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (send_s) begin
            data_valid_d = 1'b1;
            data_d       = buf_empty_s ? sw_data : mem_q[rd_ptr_q];
        end else begin
            data_valid_d = 1'b0;
            data_d       = data_q;
        end
    end

    // Staging storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= sw_data;
        end
    end

    // Datapath and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= {PTR_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= CNT_ZERO;
            data_valid_q <= 1'b0;
            data_q       <= {`DATA_WIDTH{1'b0}};
            state_q      <= ST_IDLE;
            stall_q      <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            state_q      <= state_d;
            stall_q      <= stall_d;
        end
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !send_s) state_d = ST_ACTIVE;
                else                     state_d = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (pending_s && !send_ok_s)  state_d = ST_BLOCKED;
                else if (count_d == CNT_ZERO) state_d = ST_IDLE;
                else                          state_d = ST_ACTIVE;
            end
            ST_BLOCKED: begin
                if (send_ok_s) state_d = ST_ACTIVE;
                else           state_d = ST_BLOCKED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output: stall is registered alongside the state.
    always_comb begin
        stall_d = 1'b0;
        case (state_d)
            ST_BLOCKED: stall_d = 1'b1;
            default:    stall_d = 1'b0;
        endcase
    end

`ifdef OUTPUT_UNIT_STAT_EN
    logic [15:0] flit_cnt_q, stall_cnt_q;

    assign flit_cnt  = flit_cnt_q;
    assign stall_cnt = stall_cnt_q;

    // Statistics: flit count wraps, stall count saturates, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt_q  <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else if (stat_clr) begin
            flit_cnt_q  <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (send_s) begin
                flit_cnt_q <= flit_cnt_q + 16'd1;
            end
            if ((state_q == ST_BLOCKED) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/output_unit.md
Name: output_unit

Overview:
- Transmit end of the router-to-router link. Takes flits granted by the switch/crossbar and drives them onto the link.
- The link feeds a neighbour router's input FIFO: `data_valid` is its write enable, `data` is its write data.
- Uses the neighbour FIFO's `full`/`almost_full` flags as backpressure so no flit is ever written into a full FIFO.
- Holds granted flits in a small staging buffer so the switch sees a clean ready handshake.

Parameters:
- DEPTH, 2, staging buffer entries; power of two, range 2..8.
- PTR_W, 1, log2(DEPTH); staging pointer width.
- Flit width is `DATA_WIDTH` from global.v (32); it is not a module parameter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_valid  in  1  switch presents a flit this cycle.
- sw_data  in  `DATA_WIDTH`  flit from the switch.
- sw_ready  out  1  staging buffer can accept; a transfer occurs when sw_valid && sw_ready at the rising edge.
- ds_almost_full  in  1  downstream FIFO almost_full flag (registered in the neighbour).
- ds_full  in  1  downstream FIFO full flag (registered in the neighbour).
- data_valid_out  out  1  link write strobe; one-cycle pulse per flit.
- data_out  out  `DATA_WIDTH`  link flit; registered.
- stall  out  1  a flit is pending and the link is blocked.
- buf_count  out  PTR_W+1  staging occupancy, 0..DEPTH.

Behaviour:
- Reset values: data_valid_out=0, data_out=0, stall=0, buf_count=0, state=IDLE, pointers=0. sw_ready=1 after reset.
- Reset is asynchronous. Asserting rst_n low mid-transfer discards all staged flits. data_valid_out drops immediately (no partial write).
- sw_ready = (buf_count < DEPTH); combinational from registered count only, with no combinational path from sw_valid.
- send_ok = !ds_full && !(ds_almost_full && data_valid_out). This gives a one-flit margin for flag latency: after a write, almost_full forbids a back-to-back write.
- Each cycle, send = send_ok && (buf_count != 0 || (sw_valid && sw_ready)).
  - On send: data_out <= oldest flit (staged head, else sw_data bypass); data_valid_out <= 1.
  - Otherwise data_valid_out <= 0 and data_out holds.
- Flit order is strict FIFO. A bypass is allowed only when the buffer is empty.
- Latency: with an empty buffer and send_ok=1, a flit accepted at edge t is on data_out with data_valid_out=1 after edge t (1 cycle).
- Simultaneous accept and send: the count is unchanged. When full (count=DEPTH), a send frees a slot but sw_ready stays 0 that cycle; no same-cycle refill.
- Pointers wrap modulo DEPTH.
- State machine (drives stall):
  - IDLE: buf_count=0 and no pending bypass. Go to ACTIVE on accept without send.
  - ACTIVE: flits pending and the last attempt was allowed. Go to BLOCKED when pending && !send_ok. Go to IDLE when the count reaches 0.
  - BLOCKED: stall=1. Go to ACTIVE on the first cycle send_ok=1 (the send happens that cycle).
- stall is registered: stall=1 exactly while state==BLOCKED.
- ds_full=1 overrides everything: data_valid_out is never 1 in the cycle after an edge where ds_full was sampled 1.

Optional Feature:
- Macro OUTPUT_UNIT_STAT_EN.
- When defined, add these ports:
  - flit_cnt  out  16: increments on each sent flit, wraps at 16'hFFFF->0.
  - stall_cnt  out  16: increments each cycle in BLOCKED, saturates at 16'hFFFF.
  - stat_clr  in  1: synchronous clear of both counters; clear wins over an increment in the same cycle.
  - Both counters reset to 0 on rst_n.
- When not defined: no such ports or logic; all other behaviour is identical.

Test Plan:
- Reset, then sw_valid=1 with sw_data=32'hA5A5_0001, downstream flags 0 -> sw_ready=1; next cycle data_valid_out=1, data_out=32'hA5A5_0001, buf_count=0, stall=0.
- Burst of 4 flits 0x10..0x13 with ds_almost_full=1 after the first send -> sends are spaced at least 2 cycles apart and arrive in order 0x10..0x13; a model 8-deep downstream FIFO never overflows.
- Hold ds_full=1 and push 3 flits (DEPTH=2):
  - Expected: buf_count=2, sw_ready=0, stall=1, data_valid_out=0 throughout, third flit stalls at the switch.
  - Release ds_full: flits drain in order 1 per cycle and stall=0 on the first send cycle.
- Buffer full with ds_full dropping while sw_valid=1 -> count goes 2->1, sw_ready=0 that cycle, then 1; no flit duplicated or lost (scoreboard).
- Assert rst_n=0 mid-burst with buf_count=2 -> outputs are immediately 0 and buf_count=0; after release, the first new flit 32'hDEAD_BEEF is sent alone.
- With OUTPUT_UNIT_STAT_EN: 5 sends and 7 blocked cycles -> flit_cnt=5, stall_cnt=7. Pulse stat_clr -> both 0 the next cycle.
